wb_queue: RTL and testbench

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_queue.sv | 110 +++++++++++
 tb/tb_wb_queue.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// Writeback queue between result producers and the register-file write port.
// Define WB_QUEUE_FORWARD_EN to enable read-port forwarding from pending entries.
module wb_queue #(
    parameter int WORDSIZE = 64,
    parameter int DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4:0]                 in_addr,
    input  logic [WORDSIZE-1:0]        in_data,
    output logic                       write_en,
    output logic [4:0]                 write_addr,
    output logic [WORDSIZE-1:0]        write_data,
    input  logic [4:0]                 fwd_addr_a,
    input  logic [4:0]                 fwd_addr_b,
    output logic                       fwd_hit_a,
    output logic                       fwd_hit_b,
    output logic [WORDSIZE-1:0]        fwd_data_a,
    output logic [WORDSIZE-1:0]        fwd_data_b,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [CW-1:0]       cnt;
    logic [4:0]          mem_addr [DEPTH];
    logic [WORDSIZE-1:0] mem_data [DEPTH];
    logic                push;
    logic                pop;

    assign count    = cnt;
    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign in_ready = !full;

    // Writes to x0 complete the handshake but are dropped here.
    assign push = in_valid && in_ready && (in_addr != 5'd0);
    assign pop  = !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr[i] <= '0;
                mem_data[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_addr[wr_ptr] <= in_addr;
                mem_data[wr_ptr] <= in_data;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign write_en   = !empty;
    assign write_addr = empty ? 5'd0 : mem_addr[rd_ptr];
    assign write_data = empty ? '0 : mem_data[rd_ptr];

`ifdef WB_QUEUE_FORWARD_EN
    logic [PW-1:0] idx;

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        fwd_hit_a  = 1'b0;
        fwd_hit_b  = 1'b0;
        fwd_data_a = '0;
        fwd_data_b = '0;
        idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < cnt) begin
                if (fwd_addr_a != 5'd0 && mem_addr[idx] == fwd_addr_a) begin
                    fwd_hit_a  = 1'b1;
                    fwd_data_a = mem_data[idx];
                end
                if (fwd_addr_b != 5'd0 && mem_addr[idx] == fwd_addr_b) begin
                    fwd_hit_b  = 1'b1;
                    fwd_data_b = mem_data[idx];
                end
            end
        end
    end
`else
    wire unused_fwd = ^{fwd_addr_a, fwd_addr_b};

    assign fwd_hit_a  = 1'b0;
    assign fwd_hit_b  = 1'b0;
    assign fwd_data_a = '0;
    assign fwd_data_b = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Randomised self-checking bench for wb_queue against a queue-based model.
// Forwarding expectations follow WB_QUEUE_FORWARD_EN.
module tb_wb_queue;

    localparam int W     = 64;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef WB_QUEUE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_addr;
    logic [W-1:0]  in_data;
    logic          write_en;
    logic [4:0]    write_addr;
    logic [W-1:0]  write_data;
    logic [4:0]    fwd_addr_a;
    logic [4:0]    fwd_addr_b;
    logic          fwd_hit_a;
    logic          fwd_hit_b;
    logic [W-1:0]  fwd_data_a;
    logic [W-1:0]  fwd_data_b;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]   a;
        logic [W-1:0] d;
    } ent_t;

    ent_t q[$];

    wb_queue #(.WORDSIZE(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data),
        .write_en(write_en), .write_addr(write_addr),
        .write_data(write_data),
        .fwd_addr_a(fwd_addr_a), .fwd_addr_b(fwd_addr_b),
        .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
        .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Youngest stored entry whose index matches; x0 never forwards.
    function automatic void fwd_ref(input logic [4:0] a,
                                    output logic h,
                                    output logic [W-1:0] d);
        h = 1'b0;
        d = '0;
        if (FWD && a != 5'd0) begin
            foreach (q[i]) begin
                if (q[i].a == a) begin
                    h = 1'b1;
                    d = q[i].d;
                end
            end
        end
    endfunction

    task automatic drive(input logic v, input logic [4:0] a,
                         input logic [W-1:0] d,
                         input logic [4:0] fa, input logic [4:0] fb);
        in_valid   = v;
        in_addr    = a;
        in_data    = d;
        fwd_addr_a = fa;
        fwd_addr_b = fb;
        #1;
    endtask

    // One clock: model sees the same pre-edge state as the DUT.
    task automatic tick();
        bit rdy;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
        end else begin
            rdy = (q.size() < DEPTH);
            if (q.size() != 0) void'(q.pop_front());
            if (in_valid && rdy && in_addr != 5'd0)
                q.push_back('{a: in_addr, d: in_data});
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 5'd0, '0, 5'd3, 5'd7);
        #1;
        total++;
        if (count !== '0 || empty !== 1'b1 || full !== 1'b0 ||
            in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_status: count=%0d empty=%b full=%b rdy=%b want 0 1 0 1",
                     count, empty, full, in_ready);
        end
        total++;
        if (write_en !== 1'b0 || write_addr !== 5'd0 || write_data !== '0 ||
            fwd_hit_a !== 1'b0 || fwd_hit_b !== 1'b0 ||
            fwd_data_a !== '0 || fwd_data_b !== '0) begin
            bad++;
            $display("FAIL reset_outputs: we=%b wa=%0d wd=%h ha=%b hb=%b want all 0",
                     write_en, write_addr, write_data, fwd_hit_a, fwd_hit_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        drive(1'b1, 5'd13, 64'haabb, 5'd0, 5'd0);
        total++;
        if (in_ready !== 1'b1 || write_en !== 1'b0) begin
            bad++;
            $display("FAIL single_pre: rdy=%b we=%b want 1 0", in_ready, write_en);
        end
        tick();
        drive(1'b0, 5'd0, '0, 5'd0, 5'd0);
        total++;
        if (write_en !== 1'b1 || write_addr !== 5'd13 ||
            write_data !== 64'haabb) begin
            bad++;
            $display("FAIL single_write: we=%b wa=%0d wd=%h want 1 13 aabb",
                     write_en, write_addr, write_data);
        end
        tick();
        total++;
        if (empty !== 1'b1 || write_en !== 1'b0) begin
            bad++;
            $display("FAIL single_drain: empty=%b we=%b want 1 0", empty, write_en);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] dv [5];
        for (int k = 0; k < 5; k++) dv[k] = {$urandom, $urandom};
        for (int k = 0; k < 6; k++) begin
            if (k < 5) drive(1'b1, 5'(k + 1), dv[k], 5'd0, 5'd0);
            else       drive(1'b0, 5'd0, '0, 5'd0, 5'd0);
            if (k > 0) begin
                total++;
                if (write_en !== 1'b1 || write_addr !== 5'(k) ||
                    write_data !== dv[k-1]) begin
                    bad++;
                    $display("FAIL burst_order[%0d]: we=%b wa=%0d wd=%h want 1 %0d %h",
                             k, write_en, write_addr, write_data, k, dv[k-1]);
                end
            end
            tick();
        end
        total++;
        if (empty !== 1'b1) begin
            bad++;
            $display("FAIL burst_drain: empty=%b want 1", empty);
        end
    endtask

    task automatic test_forward();
        drive(1'b1, 5'd4, 64'he45fb21f, 5'd13, 5'd4);
        total++;
        if (fwd_hit_b !== 1'b0 || fwd_data_b !== '0) begin
            bad++;
            $display("FAIL fwd_unaccepted: hit=%b data=%h want 0 0", fwd_hit_b, fwd_data_b);
        end
        tick();
        drive(1'b1, 5'd4, 64'h1234, 5'd13, 5'd4);
        tick();
        drive(1'b0, 5'd0, '0, 5'd13, 5'd4);
        total++;
        if (fwd_hit_b !== FWD || fwd_data_b !== (FWD ? 64'h1234 : 64'h0)) begin
            bad++;
            $display("FAIL fwd_youngest: hit=%b data=%h want %b %h",
                     fwd_hit_b, fwd_data_b, FWD, FWD ? 64'h1234 : 64'h0);
        end
        total++;
        if (fwd_hit_a !== 1'b0 || fwd_data_a !== '0) begin
            bad++;
            $display("FAIL fwd_miss: hit=%b data=%h want 0 0", fwd_hit_a, fwd_data_a);
        end
        total++;
        if (write_addr !== 5'd4 || write_data !== 64'h1234) begin
            bad++;
            $display("FAIL fwd_order: wa=%0d wd=%h want 4 1234", write_addr, write_data);
        end
        tick();
    endtask

    task automatic test_zero_addr();
        drive(1'b1, 5'd0, 64'hffff, 5'd0, 5'd0);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL x0_ready: rdy=%b want 1", in_ready);
        end
        tick();
        drive(1'b0, 5'd0, '0, 5'd0, 5'd0);
        total++;
        if (count !== '0 || write_en !== 1'b0) begin
            bad++;
            $display("FAIL x0_dropped: count=%0d we=%b want 0 0", count, write_en);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 5'd9, 64'h99, 5'd9, 5'd9);
        tick();
        drive(1'b1, 5'd10, 64'haa, 5'd9, 5'd10);
        tick();
        total++;
        if (count !== CW'(q.size()) || write_en !== 1'b1) begin
            bad++;
            $display("FAIL prefill: count=%0d we=%b want %0d 1", count, write_en, q.size());
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (count !== '0 || write_en !== 1'b0 || fwd_hit_a !== 1'b0 ||
            fwd_hit_b !== 1'b0 || empty !== 1'b1) begin
            bad++;
            $display("FAIL async_reset: count=%0d we=%b ha=%b hb=%b empty=%b want 0 0 0 0 1",
                     count, write_en, fwd_hit_a, fwd_hit_b, empty);
        end
        tick();
        rst_n = 1'b1;
        drive(1'b1, 5'd21, 64'h2121, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, '0, 5'd0, 5'd0);
        total++;
        if (write_en !== 1'b1 || write_addr !== 5'd21 || write_data !== 64'h2121) begin
            bad++;
            $display("FAIL first_edge: we=%b wa=%0d wd=%h want 1 21 2121",
                     write_en, write_addr, write_data);
        end
        tick();
    endtask

    task automatic test_random();
        logic         h;
        logic [W-1:0] d;
        logic [4:0]   fa;
        logic [4:0]   fb;
        for (int n = 0; n < 400; n++) begin
            fa = 5'($urandom_range(0, 7));
            fb = (q.size() != 0 && $urandom_range(0, 1) == 1) ? q[0].a :
                 5'($urandom_range(0, 7));
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
                  {$urandom, $urandom}, fa, fb);
            total++;
            if (count !== CW'(q.size()) || empty !== (q.size() == 0) ||
                full !== (q.size() == DEPTH) ||
                in_ready !== (q.size() < DEPTH)) begin
                bad++;
                $display("FAIL rand_status[%0d]: count=%0d e=%b f=%b r=%b want count=%0d",
                         n, count, empty, full, in_ready, q.size());
            end
            total++;
            if (q.size() == 0) begin
                if (write_en !== 1'b0 || write_addr !== 5'd0 || write_data !== '0) begin
                    bad++;
                    $display("FAIL rand_idle[%0d]: we=%b wa=%0d wd=%h want 0 0 0",
                             n, write_en, write_addr, write_data);
                end
            end else if (write_en !== 1'b1 || write_addr !== q[0].a ||
                         write_data !== q[0].d) begin
                bad++;
                $display("FAIL rand_write[%0d]: we=%b wa=%0d wd=%h want 1 %0d %h",
                         n, write_en, write_addr, write_data, q[0].a, q[0].d);
            end
            fwd_ref(fa, h, d);
            total++;
            if (fwd_hit_a !== h || fwd_data_a !== d) begin
                bad++;
                $display("FAIL rand_fwd_a[%0d]: hit=%b data=%h want %b %h",
                         n, fwd_hit_a, fwd_data_a, h, d);
            end
            fwd_ref(fb, h, d);
            total++;
            if (fwd_hit_b !== h || fwd_data_b !== d) begin
                bad++;
                $display("FAIL rand_fwd_b[%0d]: hit=%b data=%h want %b %h",
                         n, fwd_hit_b, fwd_data_b, h, d);
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_forward();
        test_zero_addr();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
